// File: rtl/sr_excitation_driver_if.sv
// Target handshake and SR-bank excitation/feedback bundle for sr_excitation_driver.
interface sr_excitation_driver_if #(
   parameter int unsigned Width = 8
) ();
   logic             tgt_valid;
   logic [Width-1:0] tgt_data;
   logic             tgt_ready;
   logic [Width-1:0] q_fb;
   logic [Width-1:0] s_out;
   logic [Width-1:0] r_out;
   logic             busy;
   logic             done;
   logic [Width-1:0] mismatch;

   modport master (
      output tgt_valid, tgt_data, q_fb,
      input  tgt_ready, s_out, r_out, busy, done, mismatch
   );

   modport slave (
      input  tgt_valid, tgt_data, q_fb,
      output tgt_ready, s_out, r_out, busy, done, mismatch
   );
endinterface

// File: rtl/sr_excitation_driver.sv
// Drives a bank of SR flip-flops toward a target word, then checks the bank feedback.
// Define SR_EXCITE_FORCE_EN to excite every bit explicitly instead of only changed bits.
module sr_excitation_driver #(
   parameter int unsigned Width       = 8,
   parameter int unsigned DriveCycles = 1
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   sr_excitation_driver_if.slave bus_io
);

   localparam int unsigned CntW = (DriveCycles > 1) ? $clog2(DriveCycles) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StSettle} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [Width-1:0] tgt_q, tgt_d;
   logic [Width-1:0] s_q, s_d;
   logic [Width-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic [Width-1:0] mismatch_q, mismatch_d;
   logic [Width-1:0] set_exc, rst_exc;

   // Set and reset terms are derived from t and ~t, so they can never both be high.
`ifdef SR_EXCITE_FORCE_EN
   assign set_exc = bus_io.tgt_data;
   assign rst_exc = ~bus_io.tgt_data;
`else
   assign set_exc = bus_io.tgt_data & ~bus_io.q_fb;
   assign rst_exc = ~bus_io.tgt_data & bus_io.q_fb;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      s_d        = s_q;
      r_d        = r_q;
      done_d     = 1'b0;
      mismatch_d = mismatch_q;
      unique case (state_q)
         StIdle: begin
            if (bus_io.tgt_valid) begin
               tgt_d   = bus_io.tgt_data;
               s_d     = set_exc;
               r_d     = rst_exc;
               cnt_d   = '0;
               state_d = StDrive;
            end
         end
         StDrive: begin
            if (cnt_q == CntW'(DriveCycles - 1)) begin
               s_d     = '0;
               r_d     = '0;
               state_d = StSettle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSettle: begin
            mismatch_d = bus_io.q_fb ^ tgt_q;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: begin
            s_d     = '0;
            r_d     = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         tgt_q      <= '0;
         s_q        <= '0;
         r_q        <= '0;
         done_q     <= 1'b0;
         mismatch_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_q      <= tgt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign bus_io.tgt_ready = (state_q == StIdle);
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.s_out     = s_q;
   assign bus_io.r_out     = r_q;
   assign bus_io.done      = done_q;
   assign bus_io.mismatch  = mismatch_q;

endmodule
